// File: rtl/trace_packet_fifo.sv
// Elastic buffer between the trace state machine and the USB FIFO transmitter.
// Circular RAM with a registered first-word-fall-through output stage. Words
// that arrive while the buffer is full, or while an overflow is still
// unreported, are dropped and counted. Once there is room and the producer is
// idle, the buffer enqueues the marker {OVF_TAG, drop_count}.
module trace_packet_fifo #(
  parameter int          DEPTH_LOG2 = 9,
  parameter logic [15:0] OVF_TAG    = 16'hFFFF
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic [31:0]           in_data,
  input  logic                  in_strobe,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [DEPTH_LOG2:0]   high_water,
  output logic                  drop_pending
);

  localparam int                DEPTH = 1 << DEPTH_LOG2;
  localparam int                PW    = DEPTH_LOG2;
  localparam int                FW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [31:0]         mem_q [DEPTH];
  logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]         out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [FW-1:0]       hw_q, hw_d;
  logic                drop_pending_q, drop_pending_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  logic                not_full, wr_acc, drop, mark, wr_en, pop, load;
  logic [FW-1:0]       ram_cnt;
  logic [31:0]         wr_word;

  // Write/drop/marker decisions, output-stage refill and counter updates.
  // Room is judged on the fill level at the start of the cycle, so a pop in
  // the same cycle never makes room for an incoming word.
  always_comb begin
    not_full = fill_q < FULL;
    wr_acc   = in_strobe && !drop_pending_q && not_full;
    drop     = in_strobe && (!not_full || drop_pending_q);
    mark     = drop_pending_q && !in_strobe && not_full;
    wr_en    = wr_acc || mark;
    wr_word  = mark ? {OVF_TAG, drop_cnt_q} : in_data;

    // RAM occupancy excludes the word sitting in the output register; the
    // output register never loads a word written in the same cycle.
    ram_cnt  = fill_q - FW'(out_valid_q);
    pop      = out_valid_q && out_ready;
    load     = (ram_cnt != '0) && (!out_valid_q || pop);

    wptr_d      = wptr_q + PW'(wr_en);
    rptr_d      = rptr_q + PW'(load);
    out_data_d  = load ? mem_q[rptr_q] : out_data_q;
    out_valid_d = load || (out_valid_q && !pop);
    fill_d      = fill_q + FW'(wr_en) - FW'(pop);
    hw_d        = (fill_d > hw_q) ? fill_d : hw_q;

    drop_pending_d = drop_pending_q;
    drop_cnt_d     = drop_cnt_q;
    if (drop) begin
      drop_pending_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
    if (mark) begin
      drop_pending_d = 1'b0;
      drop_cnt_d     = 16'd0;
    end
  end

  // Control and output state; reset discards everything queued.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      fill_q         <= '0;
      hw_q           <= '0;
      drop_pending_q <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      fill_q         <= fill_d;
      hw_q           <= hw_d;
      drop_pending_q <= drop_pending_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge mclk) begin
    if (wr_en) mem_q[wptr_q] <= wr_word;
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign fill_level   = fill_q;
  assign high_water   = hw_q;
  assign drop_pending = drop_pending_q;

  // Occupancy stays within the buffer and a pop never hits an empty buffer.
  a_no_overflow:  assert property (@(posedge mclk) disable iff (!reset) fill_q <= FULL);
  a_no_underflow: assert property (@(posedge mclk) disable iff (!reset) !(pop && fill_q == '0));

endmodule

// File: tb/tb_trace_packet_fifo.sv
// Bench for trace_packet_fifo: a deep instance (flow, backpressure, reset)
// and an 8-entry instance (overflow, markers, counter saturation).
module tb_trace_packet_fifo;

  logic        mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Deep instance
  logic        b_rst_n, b_strobe, b_ready, b_valid, b_dp;
  logic [31:0] b_din, b_data;
  logic [9:0]  b_fill, b_hw;
  // Small instance
  logic        s_rst_n, s_strobe, s_ready, s_valid, s_dp;
  logic [31:0] s_din, s_data;
  logic [3:0]  s_fill, s_hw;

  trace_packet_fifo #(.DEPTH_LOG2(9)) u_big (
    .mclk(mclk), .reset(b_rst_n), .in_data(b_din), .in_strobe(b_strobe),
    .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
    .fill_level(b_fill), .high_water(b_hw), .drop_pending(b_dp));

  trace_packet_fifo #(.DEPTH_LOG2(3)) u_small (
    .mclk(mclk), .reset(s_rst_n), .in_data(s_din), .in_strobe(s_strobe),
    .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready),
    .fill_level(s_fill), .high_water(s_hw), .drop_pending(s_dp));

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] qb[$];
  logic [31:0] qs[$];
  logic [31:0] be, se;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Scoreboards: every accepted pop must match the oldest expected word.
  always @(negedge mclk) begin
    if (b_rst_n && b_valid && b_ready) begin
      be = (qb.size() != 0) ? qb.pop_front() : 32'hDEADBEEF;
      chk("b_data", b_data, be);
    end
  end

  always @(negedge mclk) begin
    if (s_rst_n && s_valid && s_ready) begin
      se = (qs.size() != 0) ? qs.pop_front() : 32'hDEADBEEF;
      chk("s_data", s_data, se);
    end
  end

  initial begin
    b_rst_n = 0; s_rst_n = 0;
    b_strobe = 0; b_ready = 0; b_din = '0;
    s_strobe = 0; s_ready = 0; s_din = '0;
    tick(); tick();
    chk("rst_valid", b_valid, 0);
    chk("rst_data",  b_data,  0);
    chk("rst_fill",  b_fill,  0);
    chk("rst_hw",    b_hw,    0);
    chk("rst_dp",    b_dp,    0);
    chk("rst_s_fill", s_fill, 0);
    b_rst_n = 1; s_rst_n = 1;
    tick();

    // ---- Basic flow ----
    b_ready = 1;
    b_strobe = 1; b_din = 32'd1; qb.push_back(32'd1);
    tick();
    chk("lat_edge0", b_valid, 0);
    b_din = 32'd2; qb.push_back(32'd2);
    tick();
    chk("lat_edge1", b_valid, 1);
    chk("lat_word",  b_data, 32'd1);
    b_din = 32'd3; qb.push_back(32'd3);
    tick();
    b_strobe = 0;
    tick();
    chk("flow_word3", b_data, 32'd3);
    repeat (3) tick();
    chk("flow_fill", b_fill, 0);
    chk("flow_valid", b_valid, 0);

    // ---- Backpressure ----
    b_ready = 0;
    for (int i = 0; i < 10; i++) begin
      b_strobe = 1; b_din = 32'h100 + i; qb.push_back(32'h100 + i);
      tick();
    end
    b_strobe = 0;
    tick();
    chk("bp_fill", b_fill, 10);
    chk("bp_head", b_data, 32'h100);
    repeat (3) tick();
    chk("bp_hold", b_data, 32'h100);
    b_ready = 1;
    repeat (12) tick();
    chk("bp_drain", b_fill, 0);
    chk("bp_hw", b_hw, 10);

    // ---- Reset mid-operation ----
    b_ready = 0;
    for (int i = 0; i < 5; i++) begin
      b_strobe = 1; b_din = 32'h600 + i; qb.push_back(32'h600 + i);
      tick();
    end
    b_strobe = 0;
    tick();
    chk("pre_rst_fill", b_fill, 5);
    #1 b_rst_n = 0;
    #1;
    chk("arst_valid", b_valid, 0);
    chk("arst_fill",  b_fill,  0);
    chk("arst_hw",    b_hw,    0);
    chk("arst_dp",    b_dp,    0);
    qb.delete();
    #1 b_rst_n = 1;
    tick();
    b_ready = 1;
    b_strobe = 1; b_din = 32'h55; qb.push_back(32'h55);
    tick();
    b_strobe = 0;
    chk("post_rst_lat0", b_valid, 0);
    tick();
    chk("post_rst_valid", b_valid, 1);
    chk("post_rst_word",  b_data, 32'h55);
    tick();

    // ---- Overflow (8 entries) ----
    s_ready = 0;
    for (int i = 0; i < 11; i++) begin
      s_strobe = 1; s_din = 32'h200 + i;
      if (i < 8) qs.push_back(32'h200 + i);
      tick();
    end
    s_strobe = 0;
    chk("ovf_fill", s_fill, 8);
    chk("ovf_dp",   s_dp,   1);
    chk("ovf_hw",   s_hw,   8);
    tick();
    chk("ovf_idle_fill", s_fill, 8);
    chk("ovf_idle_dp",   s_dp,   1);
    s_ready = 1;
    tick();
    s_ready = 0;
    chk("ovf_pop_fill", s_fill, 7);
    qs.push_back(32'hFFFF0003);
    tick();
    chk("ovf_mark_fill", s_fill, 8);
    chk("ovf_mark_dp",   s_dp,   0);
    s_ready = 1;
    repeat (10) tick();
    chk("ovf_drain", s_fill, 0);

    // ---- Full with simultaneous pop ----
    s_ready = 0;
    for (int i = 0; i < 8; i++) begin
      s_strobe = 1; s_din = 32'h300 + i; qs.push_back(32'h300 + i);
      tick();
    end
    s_din = 32'h3FF; s_strobe = 1; s_ready = 1;
    tick();
    chk("fullpop_fill", s_fill, 7);
    chk("fullpop_dp",   s_dp,   1);
    s_strobe = 0; s_ready = 0;
    qs.push_back(32'hFFFF0001);
    tick();
    chk("fullpop_mark_fill", s_fill, 8);
    chk("fullpop_mark_dp",   s_dp,   0);
    s_ready = 1;
    repeat (10) tick();
    chk("fullpop_drain", s_fill, 0);

    // ---- Drop counter saturation and ordering ----
    s_ready = 0;
    for (int i = 0; i < 8; i++) begin
      s_strobe = 1; s_din = 32'h400 + i; qs.push_back(32'h400 + i);
      tick();
    end
    s_din = 32'hDEAD0000;
    for (int i = 0; i < 70000; i++) tick();
    chk("sat_dp", s_dp, 1);
    s_strobe = 0; s_ready = 1;
    qs.push_back(32'hFFFFFFFF);
    tick();
    chk("sat_pop_fill", s_fill, 7);
    chk("sat_pop_dp",   s_dp,   1);
    tick();
    chk("sat_mark_fill", s_fill, 7);
    chk("sat_mark_dp",   s_dp,   0);
    s_strobe = 1; s_din = 32'hABCD0000; qs.push_back(32'hABCD0000);
    tick();
    s_strobe = 0;
    repeat (12) tick();
    chk("sat_drain", s_fill, 0);

    // ---- Counter restarted: a single drop yields count 1 ----
    s_ready = 0;
    for (int i = 0; i < 8; i++) begin
      s_strobe = 1; s_din = 32'h500 + i; qs.push_back(32'h500 + i);
      tick();
    end
    s_din = 32'h5FF;
    tick();
    s_strobe = 0; s_ready = 1;
    qs.push_back(32'hFFFF0001);
    repeat (12) tick();
    chk("restart_drain", s_fill, 0);
    chk("restart_dp",    s_dp,   0);

    chk("sb_b_empty", qb.size(), 0);
    chk("sb_s_empty", qs.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
